id_ex_stage: RTL and testbench

- Decode/issue pipeline stage directly downstream of the register file: takes IF/ID fields plus the two asynchronous register-file read ports (OUT1/OUT2) and latches the ID/EX pipeline register.
- Resolves operand forwarding from EX, MEM and WB, because a same-cycle register-file write is not yet visible on the read ports.
- Detects load-use hazards: inserts a one-cycle bubble and stalls upstream.
- Honours EX back-pressure and branch flush; keeps a saturating bubble counter for performance monitoring.

---
 rtl/id_ex_stage.sv | 182 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with operand forwarding, load-use hazard
//   detection, EX back-pressure, branch flush and a saturating bubble counter.
//
// Ports
//   CLK, RESET                 clock (rising edge), async active-low reset
//   ID_*                       decoded IF/ID instruction fields
//   RF_OUT1, RF_OUT2           asynchronous register-file read data
//   EX_RESULT                  result of the instruction held in EXO_*
//   MEM_RD/WRITE/RESULT        MEM-stage writer for forwarding
//   WB_RD/WRITE/DATA           WB-stage writer for forwarding
//   EX_BUSY, FLUSH             EX back-pressure, branch/jump kill
//   STALL                      hold PC and IF/ID (combinational)
//   EXO_*                      registered ID/EX pipeline contents
//   BUBBLE_CNT                 saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ID_VALID,
   input  logic [XLEN-1:0]   ID_PC,
   input  logic [4:0]        ID_RS1,
   input  logic [4:0]        ID_RS2,
   input  logic [4:0]        ID_RD,
   input  logic              ID_USE_RS1,
   input  logic              ID_USE_RS2,
   input  logic [XLEN-1:0]   ID_IMM,
   input  logic [CTRL_W-1:0] ID_CTRL,
   input  logic [XLEN-1:0]   RF_OUT1,
   input  logic [XLEN-1:0]   RF_OUT2,
   input  logic [XLEN-1:0]   EX_RESULT,
   input  logic [4:0]        MEM_RD,
   input  logic              MEM_WRITE,
   input  logic [XLEN-1:0]   MEM_RESULT,
   input  logic [4:0]        WB_RD,
   input  logic              WB_WRITE,
   input  logic [XLEN-1:0]   WB_DATA,
   input  logic              EX_BUSY,
   input  logic              FLUSH,
   output logic              STALL,
   output logic              EXO_VALID,
   output logic [XLEN-1:0]   EXO_PC,
   output logic [XLEN-1:0]   EXO_OP1,
   output logic [XLEN-1:0]   EXO_OP2,
   output logic [XLEN-1:0]   EXO_IMM,
   output logic [4:0]        EXO_RD,
   output logic [CTRL_W-1:0] EXO_CTRL,
   output logic [CNT_W-1:0]  BUBBLE_CNT
);

   logic              valid_q, valid_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   op1_q, op1_d;
   logic [XLEN-1:0]   op2_q, op2_d;
   logic [XLEN-1:0]   imm_q, imm_d;
   logic [4:0]        rd_q, rd_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              ex_fwd_ok_s;
   logic              lu_s;
   logic [XLEN-1:0]   fwd1_s, fwd2_s;

   // A load in EX has no data yet, so only non-load writers forward from EX.
   assign ex_fwd_ok_s = valid_q & ctrl_q[0] & ~ctrl_q[1];

   // Forwarding mux: x0 is hard zero, then EX > MEM > WB > register file.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [4:0]      a,
      input logic [XLEN-1:0] rf_data,
      input logic            ex_ok,
      input logic [4:0]      ex_rd,
      input logic [XLEN-1:0] ex_data,
      input logic            mem_we,
      input logic [4:0]      mem_rd,
      input logic [XLEN-1:0] mem_data,
      input logic            wb_we,
      input logic [4:0]      wb_rd,
      input logic [XLEN-1:0] wb_data
   );
      logic [XLEN-1:0] r;
      if (a == 5'd0) begin
         r = {XLEN{1'b0}};
      end else if (ex_ok && (ex_rd == a)) begin
         r = ex_data;
      end else if (mem_we && (mem_rd == a)) begin
         r = mem_data;
      end else if (wb_we && (wb_rd == a)) begin
         r = wb_data;
      end else begin
         r = rf_data;
      end
      return r;
   endfunction

   // Operand forwarding for both source registers.
   always_comb begin
      fwd1_s = fwd_sel(ID_RS1, RF_OUT1, ex_fwd_ok_s, rd_q, EX_RESULT,
                       MEM_WRITE, MEM_RD, MEM_RESULT, WB_WRITE, WB_RD, WB_DATA);
      fwd2_s = fwd_sel(ID_RS2, RF_OUT2, ex_fwd_ok_s, rd_q, EX_RESULT,
                       MEM_WRITE, MEM_RD, MEM_RESULT, WB_WRITE, WB_RD, WB_DATA);
   end

   // Load-use hazard: the load in EX produces a register ID actually reads.
   assign lu_s = ID_VALID & valid_q & ctrl_q[1] & (rd_q != 5'd0) &
                 ((ID_USE_RS1 & (rd_q == ID_RS1)) | (ID_USE_RS2 & (rd_q == ID_RS2)));

   // Upstream stall; suppressed during reset and when a flush kills ID anyway.
   assign STALL = RESET & ~FLUSH & (EX_BUSY | lu_s);

   // Next-state selection: flush > busy > load-use bubble > normal latch.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      imm_d   = imm_q;
      rd_d    = rd_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      if (FLUSH) begin
         valid_d = 1'b0;
         ctrl_d  = {CTRL_W{1'b0}};
      end else if (EX_BUSY) begin
         valid_d = valid_q;
      end else if (lu_s) begin
         valid_d = 1'b0;
         ctrl_d  = {CTRL_W{1'b0}};
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         valid_d = ID_VALID;
         pc_d    = ID_PC;
         op1_d   = fwd1_s;
         op2_d   = fwd2_s;
         imm_d   = ID_IMM;
         rd_d    = ID_RD;
         ctrl_d  = ID_VALID ? ID_CTRL : {CTRL_W{1'b0}};
      end
   end

   // ID/EX pipeline register and bubble counter.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid_q <= 1'b0;
         pc_q    <= {XLEN{1'b0}};
         op1_q   <= {XLEN{1'b0}};
         op2_q   <= {XLEN{1'b0}};
         imm_q   <= {XLEN{1'b0}};
         rd_q    <= 5'd0;
         ctrl_q  <= {CTRL_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         imm_q   <= imm_d;
         rd_q    <= rd_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign EXO_VALID  = valid_q;
   assign EXO_PC     = pc_q;
   assign EXO_OP1    = op1_q;
   assign EXO_OP2    = op2_q;
   assign EXO_IMM    = imm_q;
   assign EXO_RD     = rd_q;
   assign EXO_CTRL   = ctrl_q;
   assign BUBBLE_CNT = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed self-checking bench for id_ex_stage (CNT_W = 4 so saturation is
//   reachable quickly). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 12;
   localparam int CNT_W  = 4;

   localparam logic [CTRL_W-1:0] CTRL_ALU = 12'h001;
   localparam logic [CTRL_W-1:0] CTRL_LD  = 12'h003;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              ID_VALID;
   logic [XLEN-1:0]   ID_PC;
   logic [4:0]        ID_RS1, ID_RS2, ID_RD;
   logic              ID_USE_RS1, ID_USE_RS2;
   logic [XLEN-1:0]   ID_IMM;
   logic [CTRL_W-1:0] ID_CTRL;
   logic [XLEN-1:0]   RF_OUT1, RF_OUT2, EX_RESULT;
   logic [4:0]        MEM_RD;
   logic              MEM_WRITE;
   logic [XLEN-1:0]   MEM_RESULT;
   logic [4:0]        WB_RD;
   logic              WB_WRITE;
   logic [XLEN-1:0]   WB_DATA;
   logic              EX_BUSY, FLUSH;
   logic              STALL, EXO_VALID;
   logic [XLEN-1:0]   EXO_PC, EXO_OP1, EXO_OP2, EXO_IMM;
   logic [4:0]        EXO_RD;
   logic [CTRL_W-1:0] EXO_CTRL;
   logic [CNT_W-1:0]  BUBBLE_CNT;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .ID_VALID(ID_VALID), .ID_PC(ID_PC),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
      .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
      .ID_IMM(ID_IMM), .ID_CTRL(ID_CTRL),
      .RF_OUT1(RF_OUT1), .RF_OUT2(RF_OUT2), .EX_RESULT(EX_RESULT),
      .MEM_RD(MEM_RD), .MEM_WRITE(MEM_WRITE), .MEM_RESULT(MEM_RESULT),
      .WB_RD(WB_RD), .WB_WRITE(WB_WRITE), .WB_DATA(WB_DATA),
      .EX_BUSY(EX_BUSY), .FLUSH(FLUSH), .STALL(STALL),
      .EXO_VALID(EXO_VALID), .EXO_PC(EXO_PC), .EXO_OP1(EXO_OP1),
      .EXO_OP2(EXO_OP2), .EXO_IMM(EXO_IMM), .EXO_RD(EXO_RD),
      .EXO_CTRL(EXO_CTRL), .BUBBLE_CNT(BUBBLE_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [CTRL_W-1:0] ctrl);
      ID_VALID   = v;
      ID_PC      = pc;
      ID_RS1     = rs1;
      ID_RS2     = rs2;
      ID_RD      = rd;
      ID_USE_RS1 = u1;
      ID_USE_RS2 = u2;
      ID_IMM     = pc + 32'd100;
      ID_CTRL    = ctrl;
   endtask

   // One dependent load pair: exactly one bubble.
   task automatic make_hazard();
      issue(1'b1, 32'h400, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, CTRL_LD);
      tick();
      issue(1'b1, 32'h404, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, CTRL_ALU);
      tick();
   endtask

   initial begin
      RESET = 1'b0;
      issue(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 12'h000);
      RF_OUT1 = 32'h0; RF_OUT2 = 32'h0; EX_RESULT = 32'h0;
      MEM_RD = 5'd0; MEM_WRITE = 1'b0; MEM_RESULT = 32'h0;
      WB_RD = 5'd0; WB_WRITE = 1'b0; WB_DATA = 32'h0;
      EX_BUSY = 1'b1; FLUSH = 1'b0;
      tick();
      check("rst_valid", EXO_VALID, 1'b0);
      check("rst_cnt", BUBBLE_CNT, 4'h0);
      check("rst_stall", STALL, 1'b0);
      EX_BUSY = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;

      // Plain ALU op, operands from the register file.
      issue(1'b1, 32'h100, 5'd6, 5'd7, 5'd1, 1'b1, 1'b1, CTRL_ALU);
      RF_OUT1 = 32'd10; RF_OUT2 = 32'd20;
      tick();
      check("add1_valid", EXO_VALID, 1'b1);
      check("add1_rd", EXO_RD, 5'd1);
      check("add1_op1", EXO_OP1, 32'd10);
      check("add1_op2", EXO_OP2, 32'd20);
      check("add1_imm", EXO_IMM, 32'h164);

      // ADD x2,x1,x1 forwards from EX.
      issue(1'b1, 32'h104, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, CTRL_ALU);
      RF_OUT1 = 32'h111; RF_OUT2 = 32'h111; EX_RESULT = 32'd95;
      #1;
      check("add2_stall", STALL, 1'b0);
      tick();
      check("add2_op1", EXO_OP1, 32'd95);
      check("add2_op2", EXO_OP2, 32'd95);
      check("add2_pc", EXO_PC, 32'h104);

      // Forwarding priority on x5.
      issue(1'b1, 32'h108, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, CTRL_ALU);
      tick();
      issue(1'b1, 32'h10C, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, CTRL_ALU);
      RF_OUT1 = 32'hAAA; RF_OUT2 = 32'hBBB; EX_RESULT = 32'd7;
      MEM_RD = 5'd5; MEM_WRITE = 1'b1; MEM_RESULT = 32'd8;
      WB_RD = 5'd5; WB_WRITE = 1'b1; WB_DATA = 32'd9;
      tick();
      check("prio_ex", EXO_OP1, 32'd7);
      check("prio_x0_op2", EXO_OP2, 32'd0);
      issue(1'b1, 32'h110, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, CTRL_ALU);
      tick();
      check("prio_mem", EXO_OP1, 32'd8);
      issue(1'b1, 32'h114, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, CTRL_ALU);
      MEM_WRITE = 1'b0;
      tick();
      check("prio_wb", EXO_OP1, 32'd9);
      issue(1'b1, 32'h118, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, CTRL_ALU);
      MEM_RD = 5'd0; MEM_WRITE = 1'b1; WB_RD = 5'd0; WB_WRITE = 1'b1;
      RF_OUT1 = 32'h55;
      tick();
      check("prio_x0", EXO_OP1, 32'd0);
      MEM_WRITE = 1'b0; WB_WRITE = 1'b0;

      // LW x3 then ADD x4,x3,x0.
      issue(1'b1, 32'h120, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, CTRL_LD);
      tick();
      issue(1'b1, 32'h124, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, CTRL_ALU);
      RF_OUT1 = 32'h333; EX_RESULT = 32'hDEAD;
      #1;
      check("lu_stall", STALL, 1'b1);
      tick();
      check("lu_valid", EXO_VALID, 1'b0);
      check("lu_ctrl", EXO_CTRL, 12'h000);
      check("lu_cnt", BUBBLE_CNT, 4'h1);
      MEM_RD = 5'd3; MEM_WRITE = 1'b1; MEM_RESULT = 32'd108;
      #1;
      check("lu_nostall", STALL, 1'b0);
      tick();
      check("lu_op1", EXO_OP1, 32'd108);
      check("lu_rd", EXO_RD, 5'd4);
      check("lu_valid2", EXO_VALID, 1'b1);
      MEM_WRITE = 1'b0;

      // EX back-pressure with a flush in the second busy cycle.
      issue(1'b1, 32'h200, 5'd8, 5'd8, 5'd9, 1'b1, 1'b1, CTRL_ALU);
      EX_BUSY = 1'b1;
      #1;
      check("busy1_stall", STALL, 1'b1);
      tick();
      check("busy1_rd", EXO_RD, 5'd4);
      check("busy1_pc", EXO_PC, 32'h124);
      check("busy1_op1", EXO_OP1, 32'd108);
      check("busy1_valid", EXO_VALID, 1'b1);
      FLUSH = 1'b1;
      #1;
      check("busy2_flush_stall", STALL, 1'b0);
      tick();
      check("busy2_valid", EXO_VALID, 1'b0);
      check("busy2_ctrl", EXO_CTRL, 12'h000);
      check("busy2_rd", EXO_RD, 5'd4);
      FLUSH = 1'b0;
      #1;
      check("busy3_stall", STALL, 1'b1);
      tick();
      check("busy3_valid", EXO_VALID, 1'b0);
      check("busy3_pc", EXO_PC, 32'h124);
      EX_BUSY = 1'b0;

      // Invalid ID instruction behind a load: no hazard, bubble out.
      issue(1'b1, 32'h210, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, CTRL_LD);
      tick();
      issue(1'b0, 32'h214, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, CTRL_ALU);
      #1;
      check("inv_stall", STALL, 1'b0);
      tick();
      check("inv_valid", EXO_VALID, 1'b0);
      check("inv_ctrl", EXO_CTRL, 12'h000);
      check("inv_cnt", BUBBLE_CNT, 4'h1);

      // Back-to-back dependent loads: one bubble per pair.
      issue(1'b1, 32'h220, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, CTRL_LD);
      tick();
      issue(1'b1, 32'h224, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LD);
      #1;
      check("b2b_stall1", STALL, 1'b1);
      tick();
      check("b2b_cnt1", BUBBLE_CNT, 4'h2);
      check("b2b_stall1_off", STALL, 1'b0);
      tick();
      check("b2b_ld2_rd", EXO_RD, 5'd5);
      check("b2b_ld2_ctrl", EXO_CTRL, CTRL_LD);
      issue(1'b1, 32'h228, 5'd0, 5'd5, 5'd6, 1'b1, 1'b1, CTRL_ALU);
      #1;
      check("b2b_stall2", STALL, 1'b1);
      tick();
      check("b2b_cnt2", BUBBLE_CNT, 4'h3);

      // Drive the counter to saturation and beyond.
      for (int i = 0; i < 12; i++) make_hazard();
      check("sat_15", BUBBLE_CNT, 4'hF);
      for (int i = 0; i < 2; i++) make_hazard();
      check("sat_hold", BUBBLE_CNT, 4'hF);

      // Asynchronous reset mid-cycle with the stage full.
      issue(1'b1, 32'h300, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, CTRL_ALU);
      tick();
      check("full_valid", EXO_VALID, 1'b1);
      EX_BUSY = 1'b1;
      #2;
      RESET = 1'b0;
      #1;
      check("arst_valid", EXO_VALID, 1'b0);
      check("arst_pc", EXO_PC, 32'h0);
      check("arst_imm", EXO_IMM, 32'h0);
      check("arst_rd", EXO_RD, 5'd0);
      check("arst_ctrl", EXO_CTRL, 12'h000);
      check("arst_cnt", BUBBLE_CNT, 4'h0);
      check("arst_stall", STALL, 1'b0);
      EX_BUSY = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      tick();
      check("post_rst_pc", EXO_PC, 32'h300);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
